// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART packet receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHKSUM,
    HOLD
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_PARITY  = 3'd1,
    ERR_BAD_LEN = 3'd2,
    ERR_CHKSUM  = 3'd3,
    ERR_TIMEOUT = 3'd4,
    ERR_OVERRUN = 3'd5
  } err_code_t;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/pkt_timeout_cnt.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the count would reach TIMEOUT_CYC.
module pkt_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  // Count enabled cycles; a clear always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Expiry is masked by clr so a byte arriving on the last allowed cycle wins.
  always_comb begin
    expire = en && !clr && (cnt == CW'(TIMEOUT_CYC - 1));
  end

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet sequencer behind the UART receiver: header, length, payload, XOR
// checksum; writes payload to an external buffer and hands the packet over
// with a valid/ack handshake.
module uart_rx_pkt_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned         FRAME_WD    = 8,
  parameter logic [FRAME_WD-1:0] HDR_BYTE    = FRAME_WD'(HDR_BYTE_DEFAULT),
  parameter int unsigned         MAX_LEN     = 16,
  parameter int unsigned         TIMEOUT_CYC = 50000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [FRAME_WD-1:0]          rx_frame,
  input  logic                         rx_done,
  input  logic                         frame_error,
  output logic                         buf_wr_en,
  output logic [$clog2(MAX_LEN)-1:0]   buf_wr_addr,
  output logic [FRAME_WD-1:0]          buf_wr_data,
  output logic                         pkt_valid,
  output logic [$clog2(MAX_LEN+1)-1:0] pkt_len,
  input  logic                         pkt_ack,
  output logic                         err_pulse,
  output logic [2:0]                   err_code,
  output logic                         busy
);

  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  state_t              state;
  logic [LW-1:0]       len_q;
  logic [AW-1:0]       idx_q;
  logic [FRAME_WD-1:0] chk_q;
  logic                tmo_en;
  logic                tmo_clr;
  logic                tmo_expire;
  logic                len_bad;
  logic                idx_last;

  // Watchdog runs only while a packet is being collected.
  always_comb begin
    tmo_en   = (state == LEN) || (state == PAYLOAD) || (state == CHKSUM);
    tmo_clr  = rx_done || !tmo_en;
    len_bad  = (rx_frame == '0) || (rx_frame > FRAME_WD'(MAX_LEN));
    idx_last = (LW'(idx_q) == len_q - LW'(1));
  end

  pkt_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .expire(tmo_expire)
  );

  // Packet FSM with registered outputs; busy tracks the next state != HUNT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      pkt_valid   <= 1'b0;
      pkt_len     <= '0;
      err_pulse   <= 1'b0;
      err_code    <= '0;
      busy        <= 1'b0;
    end else begin
      buf_wr_en <= 1'b0;
      err_pulse <= 1'b0;
      case (state)
        HUNT: begin
          if (rx_done && !frame_error && rx_frame == HDR_BYTE) begin
            state <= LEN;
            busy  <= 1'b1;
          end
        end
        LEN: begin
          if (rx_done) begin
            if (frame_error || len_bad) begin
              err_pulse <= 1'b1;
              err_code  <= frame_error ? ERR_PARITY : ERR_BAD_LEN;
              state     <= HUNT;
              busy      <= 1'b0;
            end else begin
              len_q <= LW'(rx_frame);
              chk_q <= rx_frame;
              idx_q <= '0;
              state <= PAYLOAD;
            end
          end else if (tmo_expire) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= HUNT;
            busy      <= 1'b0;
          end
        end
        PAYLOAD: begin
          if (rx_done) begin
            if (frame_error) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_PARITY;
              state     <= HUNT;
              busy      <= 1'b0;
            end else begin
              buf_wr_en   <= 1'b1;
              buf_wr_addr <= idx_q;
              buf_wr_data <= rx_frame;
              chk_q       <= chk_q ^ rx_frame;
              if (idx_last) begin
                state <= CHKSUM;
              end else begin
                idx_q <= idx_q + AW'(1);
              end
            end
          end else if (tmo_expire) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= HUNT;
            busy      <= 1'b0;
          end
        end
        CHKSUM: begin
          if (rx_done) begin
            if (!frame_error && rx_frame == chk_q) begin
              pkt_valid <= 1'b1;
              pkt_len   <= len_q;
              state     <= HOLD;
            end else begin
              err_pulse <= 1'b1;
              err_code  <= frame_error ? ERR_PARITY : ERR_CHKSUM;
              state     <= HUNT;
              busy      <= 1'b0;
            end
          end else if (tmo_expire) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= HUNT;
            busy      <= 1'b0;
          end
        end
        HOLD: begin
          if (rx_done) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end
          if (pkt_ack) begin
            pkt_valid <= 1'b0;
            state     <= HUNT;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= HUNT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench for uart_rx_pkt_ctrl: a byte-list packet model predicts
// writes, errors and packet handovers with their cycle stamps.
module tb_uart_rx_pkt_ctrl;

  localparam int T    = 64;
  localparam int MAXL = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_frame = '0;
  logic       rx_done = 1'b0;
  logic       frame_error = 1'b0;
  logic       pkt_ack = 1'b0;
  logic       buf_wr_en;
  logic [3:0] buf_wr_addr;
  logic [7:0] buf_wr_data;
  logic       pkt_valid;
  logic [4:0] pkt_len;
  logic       err_pulse;
  logic [2:0] err_code;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int stamp;
    int a;
    int b;
  } ev_t;

  ev_t q_wr[$];
  ev_t q_err[$];
  ev_t q_rise[$];
  ev_t q_fall[$];

  bit          m_in_pkt = 1'b0;
  bit          m_hold = 1'b0;
  int          m_last = 0;
  int unsigned m_pkt[$];

  uart_rx_pkt_ctrl #(
    .FRAME_WD   (8),
    .HDR_BYTE   (8'hA5),
    .MAX_LEN    (MAXL),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_frame   (rx_frame),
    .rx_done    (rx_done),
    .frame_error(frame_error),
    .buf_wr_en  (buf_wr_en),
    .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data),
    .pkt_valid  (pkt_valid),
    .pkt_len    (pkt_len),
    .pkt_ack    (pkt_ack),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: bytes after the header are collected in a list; the list length
  // decides whether a byte is the length, a payload byte or the checksum.
  function automatic void model_tick(input int e);
    if (m_in_pkt && (m_last + T <= e)) begin
      q_err.push_back('{m_last + T, 4, 0});
      m_in_pkt = 1'b0;
    end
  endfunction

  function automatic void model_byte(input int b, input bit fe, input int q);
    int L;
    int x;
    if (m_hold) begin
      q_err.push_back('{q, 5, 0});
      return;
    end
    if (!m_in_pkt) begin
      if (!fe && b == 'hA5) begin
        m_in_pkt = 1'b1;
        m_pkt.delete();
        m_last = q;
      end
      return;
    end
    m_last = q;
    if (fe) begin
      q_err.push_back('{q, 1, 0});
      m_in_pkt = 1'b0;
      return;
    end
    m_pkt.push_back(b);
    L = int'(m_pkt[0]);
    if (m_pkt.size() == 1) begin
      if (L == 0 || L > MAXL) begin
        q_err.push_back('{q, 2, 0});
        m_in_pkt = 1'b0;
      end
    end else if (m_pkt.size() <= L + 1) begin
      q_wr.push_back('{q, m_pkt.size() - 2, b});
    end else begin
      x = 0;
      for (int i = 0; i <= L; i++) x = x ^ int'(m_pkt[i]);
      m_in_pkt = 1'b0;
      if (x == b) begin
        m_hold = 1'b1;
        q_rise.push_back('{q, L, 0});
      end else begin
        q_err.push_back('{q, 3, 0});
      end
    end
  endfunction

  function automatic void model_ack(input int a);
    if (m_hold) begin
      m_hold = 1'b0;
      q_fall.push_back('{a, 0, 0});
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    model_tick(cyc);
  endtask

  // gap = clock edges between the previous drive's sample edge and this one.
  task automatic drive(input int b, input bit dv, input bit fe, input bit ack, input int gap);
    int q;
    repeat (gap - 1) step();
    q           = cyc + 1;
    rx_frame    = 8'(b);
    rx_done     = dv;
    frame_error = fe & dv;
    pkt_ack     = ack;
    if (dv) model_byte(b & 'hFF, fe, q);
    if (ack) model_ack(q);
    step();
    rx_done     = 1'b0;
    frame_error = 1'b0;
    pkt_ack     = 1'b0;
    rx_frame    = 8'($urandom_range(0, 255));
  endtask

  task automatic send(input int b);
    drive(b, 1'b1, 1'b0, 1'b0, 2);
  endtask

  task automatic settle_check(input string name);
    repeat (2) step();
    check({name, "_busy"}, busy, (m_in_pkt || m_hold) ? 1 : 0);
    check({name, "_pkt_valid"}, pkt_valid, m_hold ? 1 : 0);
  endtask

  function automatic int rgap();
    if ($urandom_range(0, 29) == 0) return T + int'($urandom_range(0, 1));
    return int'($urandom_range(1, 5));
  endfunction

  // Monitor: pop and compare whenever the DUT presents an event.
  ev_t        mon_e;
  logic       pv_prev = 1'b0;
  logic [4:0] len_prev = '0;
  bit         len_moved = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (buf_wr_en) begin
        if (q_wr.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          mon_e = q_wr.pop_front();
          check("wr_cycle", cyc, mon_e.stamp);
          check("wr_addr", buf_wr_addr, mon_e.a);
          check("wr_data", buf_wr_data, mon_e.b);
        end
      end
      if (err_pulse) begin
        if (q_err.size() == 0) check("err_unexpected", err_code, 0);
        else begin
          mon_e = q_err.pop_front();
          check("err_cycle", cyc, mon_e.stamp);
          check("err_code", err_code, mon_e.a);
        end
      end
      if (pkt_valid && !pv_prev) begin
        len_moved = 1'b0;
        if (q_rise.size() == 0) check("pkt_valid_unexpected", 1, 0);
        else begin
          mon_e = q_rise.pop_front();
          check("pkt_valid_cycle", cyc, mon_e.stamp);
          check("pkt_len", pkt_len, mon_e.a);
        end
      end
      if (pkt_valid && pv_prev && pkt_len != len_prev) len_moved = 1'b1;
      if (!pkt_valid && pv_prev) begin
        check("pkt_len_stable", len_moved, 0);
        if (q_fall.size() == 0) check("pkt_drop_unexpected", 1, 0);
        else begin
          mon_e = q_fall.pop_front();
          check("pkt_drop_cycle", cyc, mon_e.stamp);
        end
      end
    end
    pv_prev  = pkt_valid;
    len_prev = pkt_len;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    int len;
    int x;
    int b;

    repeat (3) step();
    check("reset_outputs", {buf_wr_en, buf_wr_addr, buf_wr_data, pkt_valid, pkt_len,
                            err_pulse, err_code, busy}, 0);
    rst_n = 1'b1;
    step();

    // Good packet preceded by garbage, held until ack.
    send('h55); send('hAA);
    send('hA5); send('h03); send('h11); send('h22); send('h33); send('h03);
    settle_check("good_held");
    repeat (5) step();
    drive(0, 1'b0, 1'b0, 1'b1, 1);
    settle_check("good_acked");

    // Bad checksum.
    send('hA5); send('h03); send('h11); send('h22); send('h33); send('h04);
    settle_check("bad_chk");

    // Length limits.
    send('hA5); send('h00);
    send('hA5); send('h11);
    settle_check("bad_len");

    // Timeout while collecting, then a byte exactly on the last allowed cycle.
    send('hA5); send('h02); send('h7E);
    repeat (T + 5) step();
    settle_check("timeout");
    send('hA5); send('h02); send('h7E);
    drive('h7F, 1'b1, 1'b0, 1'b0, T);
    send('h03);
    settle_check("edge_byte");
    drive(0, 1'b0, 1'b0, 1'b1, 2);

    // Parity error on the second payload byte, then a clean packet.
    send('hA5); send('h03); send('h11);
    drive('h22, 1'b1, 1'b1, 1'b0, 2);
    send('hA5); send('h03); send('h11); send('h22); send('h33); send('h03);
    settle_check("after_parity");
    drive(0, 1'b0, 1'b0, 1'b1, 2);

    // Overrun while a packet is pending, then overrun coinciding with ack.
    send('hA5); send('h02); send('h10); send('h20); send('h32);
    send('h5A);
    settle_check("overrun");
    drive('h5A, 1'b1, 1'b0, 1'b1, 2);
    settle_check("overrun_ack");

    // Randomised packets, including bad lengths, bad checksums, parity
    // errors, timeouts, stray acks and overruns.
    for (int p = 0; p < 80; p++) begin
      if ($urandom_range(0, 4) == 0) drive(int'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0, rgap());
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(1, MAXL));
      drive('hA5, 1'b1, 1'b0, 1'b0, rgap());
      drive(len, 1'b1, ($urandom_range(0, 39) == 0), 1'b0, rgap());
      if (len >= 1 && len <= MAXL) begin
        x = len;
        for (int i = 0; i < len; i++) begin
          b = int'($urandom_range(0, 255));
          x = x ^ b;
          drive(b, 1'b1, ($urandom_range(0, 39) == 0), 1'b0, rgap());
        end
        if ($urandom_range(0, 7) == 0) x = x ^ int'($urandom_range(1, 255));
        drive(x, 1'b1, ($urandom_range(0, 39) == 0), 1'b0, rgap());
      end
      if ($urandom_range(0, 2) == 0) drive('h5A, 1'b1, 1'b0, 1'b0, rgap());
      drive(int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), 1'b0, 1'b1, rgap());
    end
    settle_check("random_end");
    if (m_hold) drive(0, 1'b0, 1'b0, 1'b1, 2);
    if (m_in_pkt) repeat (T + 2) step();
    settle_check("drained");

    // Asynchronous reset in the middle of a payload.
    send('hA5); send('h03); send('h11);
    step();
    check("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_payload", {buf_wr_en, buf_wr_addr, buf_wr_data, pkt_valid, pkt_len,
                                err_pulse, err_code, busy}, 0);
    m_in_pkt = 1'b0;
    m_hold   = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    settle_check("after_reset");
    send('hA5); send('h01); send('h44); send('h45);
    settle_check("post_reset_pkt");
    drive(0, 1'b0, 1'b0, 1'b1, 2);

    repeat (5) step();
    check("pending_wr", q_wr.size(), 0);
    check("pending_err", q_err.size(), 0);
    check("pending_valid", q_rise.size(), 0);
    check("pending_drop", q_fall.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
